// File: rtl/c_bus_writeback.sv
// C-bus write-back stage: decodes the destination, buffers accepted writes in a
// small FIFO and issues one registered one-hot register-file strobe per cycle.
module c_bus_writeback #(
  parameter int DEPTH = 2,
  parameter int DW    = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [DW-1:0]            C_BUS_in,
  input  logic [1:0]               MUX1S,
  input  logic [4:0]               RG1_out,
  input  logic [4:0]               MUX1D_out,
  input  logic                     WB_VALID_in,
  output logic                     WB_READY_out,
  input  logic                     WB_EN_in,
  input  logic [4:0]               RD_ADDR_in,
  output logic                     PEND_HIT_out,
  output logic [15:0]              WE_out,
  output logic                     I_WE_out,
  output logic [DW-1:0]            W_DATA_out,
  output logic                     ERR_out,
  output logic [$clog2(DEPTH):0]   COUNT_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] I_CODE = 5'd23;

  function automatic logic is_legal(input logic [4:0] d);
    return ((d != 5'd0) && (d < 5'd16)) || (d == I_CODE);
  endfunction

  function automatic logic [15:0] reg_onehot(input logic [4:0] d);
    logic [15:0] r;
    r = '0;
    if ((d != 5'd0) && (d < 5'd16)) r[d[3:0]] = 1'b1;
    return r;
  endfunction

  logic [4:0]    dest_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [4:0]    iss_dest;

  logic [4:0]    dest_p0;
  logic          sel_ok_p0, acc_p0, push_p0, drop_p0, pop_p0;
  logic [4:0]    head_dest;
  logic [AW-1:0] off;
  logic          hit;

  // Stage p0: destination decode and handshake
  always_comb begin
    dest_p0   = (MUX1S == 2'd1) ? RG1_out : MUX1D_out;
    sel_ok_p0 = (MUX1S == 2'd1) || (MUX1S == 2'd2);
    acc_p0    = WB_VALID_in && WB_READY_out && sel_ok_p0;
    push_p0   = acc_p0 && is_legal(dest_p0);
    drop_p0   = acc_p0 && !is_legal(dest_p0);
    pop_p0    = (count != '0) && WB_EN_in;
    head_dest = dest_mem[rd_ptr];
  end

  assign WB_READY_out = (count < CW'(DEPTH));
  assign COUNT_out    = count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ERR_out <= 1'b0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
      if (push_p0 && !pop_p0)      count <= count + 1'b1;
      else if (!push_p0 && pop_p0) count <= count - 1'b1;
      if (drop_p0) ERR_out <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (push_p0) begin
      dest_mem[wr_ptr] <= dest_p0;
      data_mem[wr_ptr] <= C_BUS_in;
    end
  end

  // Stage p1: registered strobe; enables last exactly one cycle per entry
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      WE_out     <= '0;
      I_WE_out   <= 1'b0;
      W_DATA_out <= '0;
      iss_dest   <= '0;
    end else if (pop_p0) begin
      WE_out     <= reg_onehot(head_dest);
      I_WE_out   <= (head_dest == I_CODE);
      W_DATA_out <= data_mem[rd_ptr];
      iss_dest   <= head_dest;
    end else begin
      WE_out   <= '0;
      I_WE_out <= 1'b0;
    end
  end

  // An entry is live when its distance from the head is below the occupancy
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (dest_mem[i] == RD_ADDR_in)) hit = 1'b1;
    end
    if (((|WE_out) || I_WE_out) && (iss_dest == RD_ADDR_in)) hit = 1'b1;
    if (RD_ADDR_in == 5'd0) hit = 1'b0;
  end

  assign PEND_HIT_out = hit;

endmodule

// File: doc/c_bus_writeback.md
Name: c_bus_writeback

Overview:
- Write-side counterpart of the B-bus read mux: takes results from the C bus and writes them back into the register file (R1–R14, TOTR, i).
- Decodes the 5-bit destination code, then queues each accepted write in a small FIFO.
- Issues one registered one-hot write strobe per cycle to the register file.
- Reports pending writes so the control unit can stall dependent reads.

Parameters:
- DEPTH, 2, number of write-back buffer entries (power of two, 2..8).
- DW, 16, data width of the C bus and registers.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- C_BUS_in  input  DW  write-back data.
- MUX1S  input  2  destination source select: 1 = RG1_out, 2 = MUX1D_out, 0/3 = no write.
- RG1_out  input  5  destination code from instruction register field.
- MUX1D_out  input  5  destination code from microcode.
- WB_VALID_in  input  1  write request valid.
- WB_READY_out  output  1  buffer can accept a request.
- WB_EN_in  input  1  drain enable; 0 holds the buffer.
- RD_ADDR_in  input  5  code currently being read on the B bus (hazard check).
- PEND_HIT_out  output  1  a queued or issuing write targets RD_ADDR_in.
- WE_out  output  16  one-hot register write enable; bit n = code n (n = 1..15), bit 0 always 0.
- I_WE_out  output  1  write enable for i (code 23).
- W_DATA_out  output  DW  write data accompanying the enables.
- ERR_out  output  1  sticky illegal-destination flag.
- COUNT_out  output  log2(DEPTH)+1  current buffer occupancy.

Behaviour:
- Reset (async, immediate): FIFO emptied, pointers = 0, COUNT_out = 0, WE_out = 0, I_WE_out = 0, W_DATA_out = 0, ERR_out = 0.
- Destination selection: dest = RG1_out if MUX1S = 1; dest = MUX1D_out if MUX1S = 2.
- Accept condition: WB_VALID_in & WB_READY_out & MUX1S ∈ {1,2}.
  - WB_VALID_in with MUX1S ∈ {0,3} is consumed (handshake completes) and produces no write and no error.
- Legal codes: 1..15 and 23.
  - An accepted illegal code (0, 16..22, 24..31) is dropped, not enqueued, and sets ERR_out, which stays set until Reset.
- WB_READY_out = (COUNT < DEPTH), from current occupancy only.
  - When the buffer is full, no push occurs, even on a cycle that pops.
- Push: on the accepting edge, {dest, C_BUS_in} is written at the tail; COUNT increments.
- Pop: on any edge with COUNT > 0 and WB_EN_in = 1, the head entry is removed; COUNT decrements.
- Push and pop on the same edge leave COUNT unchanged.
- Output stage (registered):
  - On a popping edge, the head's one-hot enable is loaded into WE_out or I_WE_out, and its data into W_DATA_out.
  - On every non-popping edge, all enables clear to 0. W_DATA_out holds its last value.
  - Each entry therefore produces exactly one strobe, lasting one cycle.
- Latency: request accepted at edge k into an empty buffer with WB_EN_in = 1:
  - strobe high from edge k+1 to edge k+2;
  - register file captures at edge k+2.
- Throughput: one write per cycle while WB_EN_in = 1 and a valid request is presented every cycle.
- Ordering: strict FIFO. Two writes to the same register land in acceptance order.
- Pointer wrap-around: modulo DEPTH, with no gap or duplication.
- PEND_HIT_out (combinational): 1 when either of the following matches RD_ADDR_in:
  - any valid FIFO entry's dest, or
  - the dest of the strobe currently asserted on WE_out/I_WE_out.
  - RD_ADDR_in = 0 never hits.
- WB_EN_in = 0 with a full buffer: WB_READY_out = 0, contents preserved, no strobes.
- Reset asserted mid-operation: all queued writes are discarded and strobes drop immediately. No partial write is issued after Reset deasserts.

Test Plan:
1. Reset, then MUX1S=1, RG1_out=5, C_BUS_in=16'h1234, WB_VALID_in=1 for 1 cycle, WB_EN_in=1 -> exactly one cycle later WE_out=16'h0020 and W_DATA_out=16'h1234 for one cycle; COUNT_out returns to 0.
2. MUX1S=2, MUX1D_out=23, C_BUS_in=16'h00FF -> I_WE_out pulses once with W_DATA_out=16'h00FF; WE_out stays 0. Then code 15 -> WE_out=16'h8000.
3. WB_EN_in=0, push codes 3, 4, then attempt code 7 -> WB_READY_out=0 after 2 accepts, COUNT_out=2, code 7 not taken. Raise WB_EN_in -> strobes 16'h0008 then 16'h0010 on consecutive cycles; code 7 is accepted once ready returns.
4. Queue code 9 with WB_EN_in=0, RD_ADDR_in=9 -> PEND_HIT_out=1. RD_ADDR_in=10 -> 0. Drain -> PEND_HIT_out stays 1 through the strobe cycle, then returns to 0.
5. Accept code 18 -> no strobe, COUNT_out unchanged, ERR_out=1 and stays 1 across subsequent legal writes until Reset.
6. Fill with 2 entries, assert Reset for half a cycle -> COUNT_out=0, WE_out=0 immediately. No strobes after release; WB_READY_out=1.
